// File: rtl/pong_score_display.sv
// Pong score keeper: synchronised score strobes, PLAY/GAME_OVER control with keyboard
// restart, and a one-cycle seven-segment renderer for both scores with winner blink.
module pong_score_display #(
    parameter int         WIN_SCORE    = 9,
    parameter logic [7:0] RESTART_KEY  = 8'd114,
    parameter logic [9:0] P1_X         = 10'd280,
    parameter logic [9:0] P2_X         = 10'd340,
    parameter logic [9:0] DIGIT_Y      = 10'd20,
    parameter int         DIGIT_W      = 20,
    parameter int         DIGIT_H      = 40,
    parameter int         SEG_T        = 4,
    parameter int         BLINK_FRAMES = 32
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic       i_p1_scored,
    input  logic       i_p2_scored,
    input  logic       i_key_valid,
    input  logic [7:0] i_key_byte,
    input  logic       i_hSync,
    input  logic       i_vSync,
    input  logic [9:0] i_display_x_pos,
    input  logic [9:0] i_display_y_pos,
    output logic [2:0] o_red,
    output logic [2:0] o_green,
    output logic [2:0] o_blue,
    output logic       o_hSync,
    output logic       o_vSync,
    output logic [3:0] o_p1_score,
    output logic [3:0] o_p2_score,
    output logic       o_game_over,
    output logic       o_winner
);

    localparam logic [3:0]  WIN_S      = 4'(WIN_SCORE);
    localparam logic [9:0]  W_S        = 10'(DIGIT_W);
    localparam logic [9:0]  H_S        = 10'(DIGIT_H);
    localparam logic [9:0]  T_S        = 10'(SEG_T);
    localparam logic [9:0]  H2_S       = 10'(DIGIT_H / 2);
    localparam logic [9:0]  TH_S       = 10'(SEG_T / 2);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    // Segment bit order is {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    function automatic logic digit_lit(input logic [9:0] x, input logic [9:0] y,
                                       input logic [9:0] org_x, input logic [3:0] val);
        logic       in_box;
        logic [9:0] dx;
        logic [9:0] dy;
        logic [6:0] hit;
        in_box = (x >= org_x) && (x < org_x + W_S) && (y >= DIGIT_Y) && (y < DIGIT_Y + H_S);
        dx     = x - org_x;
        dy     = y - DIGIT_Y;
        hit[0] = (dy < T_S);
        hit[1] = (dx >= W_S - T_S) && (dy < H2_S);
        hit[2] = (dx >= W_S - T_S) && (dy >= H2_S);
        hit[3] = (dy >= H_S - T_S);
        hit[4] = (dx < T_S) && (dy >= H2_S);
        hit[5] = (dx < T_S) && (dy < H2_S);
        hit[6] = (dy >= H2_S - TH_S) && (dy < H2_S + TH_S);
        // Region hits are only meaningful inside the box, where dx/dy cannot have wrapped.
        return in_box && (|(seg_decode(val) & hit));
    endfunction

    state_t     state_q, state_d;
    logic [1:0] scored_meta_q, scored_meta_d;
    logic [1:0] scored_sync_q, scored_sync_d;
    logic [1:0] scored_prev_q, scored_prev_d;
    logic [1:0] scored_pulse_q, scored_pulse_d;
    logic [3:0] p1_score_q, p1_score_d;
    logic [3:0] p2_score_q, p2_score_d;
    logic       winner_q, winner_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic       blink_q, blink_d;
    logic       vsync_prev_q, vsync_prev_d;
    logic [2:0] rgb_q, rgb_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;

    logic [3:0] p1_inc_s, p2_inc_s;
    logic       p1_win_s, p2_win_s;
    logic       restart_s, vsync_fall_s;
    logic       p1_vis_s, p2_vis_s, lit_s;
    logic       game_over_s;

    // Synchroniser chain and registered rising-edge pulse for both score strobes.
    always_comb begin
        scored_meta_d  = {i_p2_scored, i_p1_scored};
        scored_sync_d  = scored_meta_q;
        scored_prev_d  = scored_sync_q;
        scored_pulse_d = scored_sync_q & ~scored_prev_q;
    end

    // Shared decode of score increments, wins, restart key and frame boundary.
    always_comb begin
        p1_inc_s     = p1_score_q + 4'd1;
        p2_inc_s     = p2_score_q + 4'd1;
        p1_win_s     = scored_pulse_q[0] && (p1_inc_s == WIN_S);
        p2_win_s     = scored_pulse_q[1] && (p2_inc_s == WIN_S);
        restart_s    = i_key_valid && (i_key_byte == RESTART_KEY);
        vsync_fall_s = vsync_prev_q && !i_vSync;
        vsync_prev_d = i_vSync;
    end

    // FSM state register.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= ST_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PLAY: begin
                if (p1_win_s || p2_win_s) state_d = ST_OVER;
                else                      state_d = ST_PLAY;
            end
            ST_OVER: begin
                if (restart_s) state_d = ST_PLAY;
                else           state_d = ST_OVER;
            end
            default: state_d = ST_PLAY;
        endcase
    end

    // FSM outputs.
    always_comb begin
        game_over_s = (state_q == ST_OVER);
    end

    // Scores, winner and blink timing; the frame counter only runs while the game is over.
    always_comb begin
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        winner_d    = winner_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (!game_over_s) begin
            frame_cnt_d = 16'd0;
            blink_d     = 1'b0;
            if (scored_pulse_q[0]) p1_score_d = p1_inc_s;
            else                   p1_score_d = p1_score_q;
            if (scored_pulse_q[1]) p2_score_d = p2_inc_s;
            else                   p2_score_d = p2_score_q;
            if (p1_win_s)      winner_d = 1'b0;
            else if (p2_win_s) winner_d = 1'b1;
            else               winner_d = winner_q;
        end else if (restart_s) begin
            p1_score_d  = 4'd0;
            p2_score_d  = 4'd0;
            frame_cnt_d = 16'd0;
            blink_d     = 1'b0;
        end else if (vsync_fall_s) begin
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d = 16'd0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Pixel colour for the current raster position.
    always_comb begin
        p1_vis_s = !(game_over_s && blink_q && !winner_q);
        p2_vis_s = !(game_over_s && blink_q && winner_q);
        lit_s    = (p1_vis_s && digit_lit(i_display_x_pos, i_display_y_pos, P1_X, p1_score_q)) ||
                   (p2_vis_s && digit_lit(i_display_x_pos, i_display_y_pos, P2_X, p2_score_q));
        if (lit_s) rgb_d = 3'b111;
        else       rgb_d = 3'b000;
        hsync_d = i_hSync;
        vsync_d = i_vSync;
    end

    // Datapath and output registers.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            scored_meta_q  <= 2'b00;
            scored_sync_q  <= 2'b00;
            scored_prev_q  <= 2'b00;
            scored_pulse_q <= 2'b00;
            p1_score_q     <= 4'd0;
            p2_score_q     <= 4'd0;
            winner_q       <= 1'b0;
            frame_cnt_q    <= 16'd0;
            blink_q        <= 1'b0;
            vsync_prev_q   <= 1'b0;
            rgb_q          <= 3'b000;
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
        end else begin
            scored_meta_q  <= scored_meta_d;
            scored_sync_q  <= scored_sync_d;
            scored_prev_q  <= scored_prev_d;
            scored_pulse_q <= scored_pulse_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            winner_q       <= winner_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_q        <= blink_d;
            vsync_prev_q   <= vsync_prev_d;
            rgb_q          <= rgb_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
        end
    end

    assign o_red       = rgb_q;
    assign o_green     = rgb_q;
    assign o_blue      = rgb_q;
    assign o_hSync     = hsync_q;
    assign o_vSync     = vsync_q;
    assign o_p1_score  = p1_score_q;
    assign o_p2_score  = p2_score_q;
    assign o_game_over = game_over_s;
    assign o_winner    = winner_q;

endmodule

// File: tb/tb_pong_score_display.sv
// Self-checking bench for pong_score_display: pixel vector table, hand-written game
// sequences, and a randomized run against a rule-level reference model.
module tb_pong_score_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       p1 = 1'b0, p2 = 1'b0;
    logic       kv = 1'b0;
    logic [7:0] kb = 8'd0;
    logic       hs = 1'b0, vs = 1'b0;
    logic [9:0] x = 10'd0, y = 10'd0;
    logic [2:0] o_red, o_green, o_blue;
    logic       o_hs, o_vs, o_go, o_win;
    logic [3:0] o_s1, o_s2;

    always #5 clk = ~clk;

    pong_score_display dut (
        .i_CLK(clk), .i_RST_N(rst_n),
        .i_p1_scored(p1), .i_p2_scored(p2),
        .i_key_valid(kv), .i_key_byte(kb),
        .i_hSync(hs), .i_vSync(vs),
        .i_display_x_pos(x), .i_display_y_pos(y),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_hSync(o_hs), .o_vSync(o_vs),
        .o_p1_score(o_s1), .o_p2_score(o_s2),
        .o_game_over(o_go), .o_winner(o_win)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    string pat[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    int         m_s1, m_s2, m_cnt;
    bit         m_go, m_win, m_ph, m_vsp;
    logic [4:0] h1, h2;
    int         exp_rgb;
    bit         exp_hs, exp_vs;

    function automatic bit tb_lit(input int px, input int py, input int ox, input int v);
        int  dx;
        int  dy;
        bit  hit;
        byte c;
        dx  = px - ox;
        dy  = py - 20;
        hit = 1'b0;
        if (dx < 0 || dx >= 20 || dy < 0 || dy >= 40 || v > 9) return 1'b0;
        for (int i = 0; i < pat[v].len(); i++) begin
            c = pat[v].getc(i);
            if (c == "a" && dy < 4) hit = 1'b1;
            if (c == "b" && dx >= 16 && dy < 20) hit = 1'b1;
            if (c == "c" && dx >= 16 && dy >= 20) hit = 1'b1;
            if (c == "d" && dy >= 36) hit = 1'b1;
            if (c == "e" && dx < 4 && dy >= 20) hit = 1'b1;
            if (c == "f" && dx < 4 && dy < 20) hit = 1'b1;
            if (c == "g" && dy >= 18 && dy < 22) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_cnt = 0;
        m_go = 1'b0; m_win = 1'b0; m_ph = 1'b0; m_vsp = 1'b0;
        h1 = 5'd0; h2 = 5'd0;
        exp_rgb = 0; exp_hs = 1'b0; exp_vs = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_step();
        bit r1, r2, fall, v1, v2;
        if (!rst_n) begin
            model_reset();
            return;
        end
        v1 = !(m_go && m_ph && !m_win);
        v2 = !(m_go && m_ph && m_win);
        exp_rgb = ((v1 && tb_lit(int'(x), int'(y), 280, m_s1)) ||
                   (v2 && tb_lit(int'(x), int'(y), 340, m_s2))) ? 7 : 0;
        exp_hs = hs;
        exp_vs = vs;
        h1 = {h1[3:0], p1};
        h2 = {h2[3:0], p2};
        r1 = h1[3] && !h1[4];
        r2 = h2[3] && !h2[4];
        fall = m_vsp && !vs;
        m_vsp = vs;
        if (m_go) begin
            if (kv && kb == 8'd114) begin
                m_s1 = 0; m_s2 = 0; m_go = 1'b0; m_cnt = 0; m_ph = 1'b0;
            end else if (fall) begin
                m_cnt++;
                if (m_cnt == 32) begin
                    m_cnt = 0;
                    m_ph = !m_ph;
                end
            end
        end else begin
            if (r1) m_s1++;
            if (r2) m_s2++;
            if (m_s1 == 9 || m_s2 == 9) begin
                m_go = 1'b1;
                m_win = (m_s1 == 9) ? 1'b0 : 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_all();
        check("p1_score", o_s1, m_s1);
        check("p2_score", o_s2, m_s2);
        check("game_over", o_go, m_go);
        if (m_go) check("winner", o_win, m_win);
        check("red", o_red, exp_rgb);
        check("green", o_green, exp_rgb);
        check("blue", o_blue, exp_rgb);
        check("hsync", o_hs, exp_hs);
        check("vsync", o_vs, exp_vs);
    endtask

    task automatic pulse(input bit a, input bit b);
        p1 = a; p2 = b;
        repeat (2) tick();
        p1 = 1'b0; p2 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic key(input logic [7:0] byte_v);
        kv = 1'b1; kb = byte_v;
        tick();
        kv = 1'b0; kb = 8'd0;
    endtask

    typedef struct {
        int         px;
        int         py;
        logic       h;
        logic       v;
        logic [2:0] rgb;
    } pix_vec_t;
    pix_vec_t tbl[11];

    initial begin
        tbl[0]  = '{282, 22, 1'b1, 1'b0, 3'd7};
        tbl[1]  = '{290, 40, 1'b0, 1'b1, 3'd0};
        tbl[2]  = '{279, 22, 1'b1, 1'b1, 3'd0};
        tbl[3]  = '{280, 20, 1'b0, 1'b0, 3'd7};
        tbl[4]  = '{299, 59, 1'b1, 1'b0, 3'd7};
        tbl[5]  = '{300, 30, 1'b0, 1'b1, 3'd0};
        tbl[6]  = '{290, 60, 1'b1, 1'b1, 3'd0};
        tbl[7]  = '{342, 30, 1'b0, 1'b0, 3'd7};
        tbl[8]  = '{350, 30, 1'b1, 1'b0, 3'd0};
        tbl[9]  = '{297, 45, 1'b0, 1'b1, 3'd7};
        tbl[10] = '{283, 41, 1'b1, 1'b0, 3'd7};

        model_reset();
        #2;
        check("rst_p1", o_s1, 0);
        check("rst_p2", o_s2, 0);
        check("rst_go", o_go, 0);
        check("rst_win", o_win, 0);
        check("rst_rgb", o_red, 0);
        check("rst_hs", o_hs, 0);
        check("rst_vs", o_vs, 0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Pixel table with both scores at 0.
        for (int i = 0; i < 11; i++) begin
            x = 10'(tbl[i].px); y = 10'(tbl[i].py);
            hs = tbl[i].h; vs = tbl[i].v;
            tick();
            check("pix_rgb", o_red, tbl[i].rgb);
            check("pix_blue", o_blue, tbl[i].rgb);
            check("pix_hs", o_hs, tbl[i].h);
            check("pix_vs", o_vs, tbl[i].v);
        end
        hs = 1'b0; vs = 1'b0;

        // Held score input: exactly one increment, visible after the third edge.
        p1 = 1'b1;
        tick(); check("lat_e0", o_s1, 0);
        tick(); check("lat_e1", o_s1, 0);
        tick(); check("lat_e2", o_s1, 0);
        tick(); check("lat_e3", o_s1, 1);
        repeat (96) tick();
        check("hold_p1", o_s1, 1);
        check("hold_p2", o_s2, 0);
        p1 = 1'b0;
        repeat (4) tick();
        x = 10'd282; y = 10'd22;
        tick(); check("pix_one", o_red, 0);

        // Player 2 wins; later player 1 strobes are ignored.
        repeat (9) pulse(1'b0, 1'b1);
        check("win_p2", o_s2, 9);
        check("win_go", o_go, 1);
        check("win_who", o_win, 1);
        repeat (3) pulse(1'b1, 1'b0);
        check("frozen_p1", o_s1, 1);
        check("frozen_p2", o_s2, 9);

        // Restart handling.
        key(8'd113);
        check("badkey_go", o_go, 1);
        check("badkey_p2", o_s2, 9);
        key(8'd114);
        check("restart_p1", o_s1, 0);
        check("restart_p2", o_s2, 0);
        check("restart_go", o_go, 0);
        pulse(1'b1, 1'b0);
        key(8'd114);
        tick();
        check("playkey_p1", o_s1, 1);
        check("playkey_go", o_go, 0);

        // Both at 8, then a simultaneous point: player 1 has priority.
        repeat (7) pulse(1'b1, 1'b1);
        pulse(1'b0, 1'b1);
        check("eight_p1", o_s1, 8);
        check("eight_p2", o_s2, 8);
        check("eight_go", o_go, 0);
        pulse(1'b1, 1'b1);
        check("sim_p1", o_s1, 9);
        check("sim_p2", o_s2, 9);
        check("sim_go", o_go, 1);
        check("sim_who", o_win, 0);

        // Blink: winner digit stays lit through 31 frames and hides after the 32nd.
        x = 10'd282; y = 10'd22;
        for (int i = 0; i < 31; i++) begin
            vs = 1'b1; tick();
            vs = 1'b0; tick();
        end
        tick(); check("blink_31", o_red, 7);
        vs = 1'b1; tick();
        vs = 1'b0; tick();
        tick(); check("blink_32", o_red, 0);
        x = 10'd342;
        tick(); check("blink_loser", o_red, 7);

        // Asynchronous reset in mid-line.
        hs = 1'b1; vs = 1'b1;
        tick();
        check("pre_rst_hs", o_hs, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rgb", o_red, 0);
        check("arst_hs", o_hs, 0);
        check("arst_vs", o_vs, 0);
        check("arst_p1", o_s1, 0);
        check("arst_p2", o_s2, 0);
        check("arst_go", o_go, 0);
        model_reset();
        p1 = 1'b0; p2 = 1'b0; hs = 1'b0; vs = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized play against the reference model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 5) == 0) p1 = ~p1;
            if ($urandom_range(0, 5) == 0) p2 = ~p2;
            kv = ($urandom_range(0, 59) == 0);
            kb = ($urandom_range(0, 1) == 1) ? 8'd114 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) vs = ~vs;
            hs = 1'($urandom_range(0, 1));
            x  = 10'($urandom_range(270, 370));
            y  = 10'($urandom_range(10, 70));
            tick();
            check_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
